// File: rtl/uart_rx_framed_if.sv
// Signal bundle for one uart_rx_framed receiver: the serial line in, and the received word plus status out.
// rx_done is a one-cycle valid with no ready; rx_byte and the flags are stable from rx_done until the next rx_done.
interface uart_rx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_serial;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_done;
  logic                 parity_err;
  logic                 frame_err;
  logic                 brk;
  logic                 busy;
  logic [2:0]           state;

  // master drives the line and consumes results; slave is the receiver side
  modport master (
    output rx_serial,
    input  rx_byte, rx_done, parity_err, frame_err, brk, busy, state
  );

  modport slave (
    input  rx_serial,
    output rx_byte, rx_done, parity_err, frame_err, brk, busy, state
  );
endinterface

// File: rtl/uart_rx_framed.sv
// UART receiver with configurable data width, optional parity, 1/2 stop bits, and break detection.
// o_State exposes the FSM state for debug and checker binding.
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_RX_Serial,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_RX_Done,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy,
  output logic [2:0]           o_State
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5,
    CLEANUP   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 first_stop_q, first_stop_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 cnt_last;
  logic                 first_stop_now;

  always_comb begin
    state_d        = state_q;
    rx_meta_d      = i_RX_Serial;
    rx_s_d         = rx_meta_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shift_d        = shift_q;
    par_bit_d      = par_bit_q;
    ferr_acc_d     = ferr_acc_q;
    first_stop_d   = first_stop_q;
    byte_d         = byte_q;
    done_d         = 1'b0;
    perr_d         = perr_q;
    ferr_d         = ferr_q;
    brk_d          = brk_q;
    cnt_last       = (cnt_q == CNT_LAST);
    first_stop_now = (idx_q == '0) ? rx_s_q : first_stop_q;

    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        idx_d      = '0;
        ferr_acc_d = 1'b0;
        par_bit_d  = 1'b0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // a start bit that is high again at mid-bit was a glitch
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_last) begin
          cnt_d     = '0;
          par_bit_d = rx_s_q;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_d        = '0;
          ferr_acc_d   = ferr_acc_q | ~rx_s_q;
          first_stop_d = first_stop_now;
          if (idx_q == STOP_LAST) begin
            // results land together with the one-cycle done pulse
            idx_d   = '0;
            done_d  = 1'b1;
            byte_d  = shift_q;
            perr_d  = (PARITY_EN != 0) && ((^shift_q ^ par_bit_q) != (PARITY_ODD != 0));
            ferr_d  = ferr_acc_q | ~rx_s_q;
            brk_d   = (shift_q == '0) && !par_bit_q && !first_stop_now;
            state_d = rx_s_q ? CLEANUP : WAIT_HIGH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = CLEANUP;
      end
      CLEANUP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      ferr_acc_q   <= 1'b0;
      first_stop_q <= 1'b0;
      byte_q       <= '0;
      done_q       <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      ferr_acc_q   <= ferr_acc_d;
      first_stop_q <= first_stop_d;
      byte_q       <= byte_d;
      done_q       <= done_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      brk_q        <= brk_d;
    end
  end

  assign o_RX_Byte    = byte_q;
  assign o_RX_Done    = done_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Break      = brk_q;
  assign o_Busy       = (state_q != IDLE);
  assign o_State      = state_q;
endmodule
